// File: rtl/collector_port_arbiter.sv
// Round-robin arbiter sharing one packet collector among NUM_PORTS local ports.
// Latches the winning flit, runs the ReqUpStr/GntUpStr handshake and aborts on timeout.
module collector_port_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned dataWidth = 32,
  parameter int unsigned PORT_W    = 2,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned TO_W      = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           ReqDnStr,
  input  logic [NUM_PORTS*dataWidth-1:0] PacketOut,
  output logic [NUM_PORTS-1:0]           GntDnStr,
  output logic [NUM_PORTS-1:0]           DnStrFull,
  output logic                           ReqUpStr,
  output logic [dataWidth-1:0]           PacketIn,
  input  logic                           GntUpStr,
  input  logic                           UpStrFull,
  output logic                           Busy,
  output logic [PORT_W-1:0]              Owner,
  output logic                           TimeoutErr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_ACK  = 2'b10,
    ST_BAD  = 2'b11
  } state_e;

  state_e                 state_q;
  logic                   req_q;
  logic                   busy_q;
  logic                   terr_q;
  logic [NUM_PORTS-1:0]   gnt_q;
  logic [NUM_PORTS-1:0]   full_q;
  logic [dataWidth-1:0]   pkt_q;
  logic [PORT_W-1:0]      owner_q;
  logic [PORT_W-1:0]      ptr_q;
  logic [TO_W-1:0]        cnt_q;

  logic [dataWidth-1:0]   flit [NUM_PORTS];
  logic                   win_found;
  logic [PORT_W-1:0]      win_idx;
  logic [NUM_PORTS-1:0]   win_mask;
  logic [NUM_PORTS-1:0]   own_mask;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_flit
    assign flit[i] = PacketOut[i*dataWidth +: dataWidth];
  end

  // First requesting port after the round-robin pointer, wrapping modulo NUM_PORTS.
  always_comb begin
    logic [PORT_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = PORT_W'((32'(ptr_q) + k) % NUM_PORTS);
      if (!win_found && ReqDnStr[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_mask          = '0;
    win_mask[win_idx] = 1'b1;
    own_mask          = '0;
    own_mask[owner_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      gnt_q   <= '0;
      full_q  <= '0;
      pkt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= PORT_W'(NUM_PORTS - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found && !UpStrFull) begin
            owner_q <= win_idx;
            pkt_q   <= flit[win_idx];
            req_q   <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            full_q  <= ~win_mask;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_q + TO_W'(1);
          // A grant arriving on the final wait cycle still counts as success.
          if (GntUpStr) begin
            req_q   <= 1'b0;
            gnt_q   <= own_mask;
            ptr_q   <= owner_q;
            state_q <= ST_ACK;
          end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
            req_q   <= 1'b0;
            terr_q  <= 1'b1;
            ptr_q   <= owner_q;
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          gnt_q   <= '0;
          terr_q  <= 1'b0;
          busy_q  <= 1'b0;
          full_q  <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          gnt_q   <= '0;
          terr_q  <= 1'b0;
          busy_q  <= 1'b0;
          full_q  <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign GntDnStr   = gnt_q;
  assign DnStrFull  = full_q;
  assign ReqUpStr   = req_q;
  assign PacketIn   = pkt_q;
  assign Busy       = busy_q;
  assign Owner      = owner_q;
  assign TimeoutErr = terr_q;

endmodule

// File: tb/tb_collector_port_arbiter.sv
// Randomized scoreboard bench for collector_port_arbiter with a transaction-level
// reference model that schedules each arbitration from the round-robin rules.
module tb_collector_port_arbiter;
  localparam int unsigned NP   = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned PW   = 2;
  localparam int unsigned TO   = 16;
  localparam int unsigned TW   = 5;
  localparam int          NCYC = 5000;
  localparam int          MAXE = 8192;

  logic              clk;
  logic              reset;
  logic [NP-1:0]     ReqDnStr;
  logic [NP*DW-1:0]  PacketOut;
  logic [NP-1:0]     GntDnStr;
  logic [NP-1:0]     DnStrFull;
  logic              ReqUpStr;
  logic [DW-1:0]     PacketIn;
  logic              GntUpStr;
  logic              UpStrFull;
  logic              Busy;
  logic [PW-1:0]     Owner;
  logic              TimeoutErr;

  collector_port_arbiter #(
    .NUM_PORTS(NP), .dataWidth(DW), .PORT_W(PW), .TIMEOUT(TO), .TO_W(TW)
  ) dut (
    .clk(clk), .reset(reset), .ReqDnStr(ReqDnStr), .PacketOut(PacketOut),
    .GntDnStr(GntDnStr), .DnStrFull(DnStrFull), .ReqUpStr(ReqUpStr),
    .PacketIn(PacketIn), .GntUpStr(GntUpStr), .UpStrFull(UpStrFull),
    .Busy(Busy), .Owner(Owner), .TimeoutErr(TimeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          done_edge;
    int          owner;
    logic [31:0] data;
    bit          granted;
  } exp_t;

  exp_t         sbq[$];
  bit           exp_req  [MAXE];
  bit           exp_busy [MAXE];
  logic [NP-1:0] exp_full[MAXE];
  bit           rst_edge [MAXE];
  bit           gnt_sched[MAXE];
  int           drop_at  [MAXE];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  // Monitor: per-edge handshake levels plus scoreboard pop on each completion.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXE) begin
      exp_t h;
      chk("ReqUpStr", 64'(ReqUpStr), 64'(exp_req[cyc]));
      chk("Busy", 64'(Busy), 64'(exp_busy[cyc]));
      chk("DnStrFull", 64'(DnStrFull), 64'(exp_busy[cyc] ? exp_full[cyc] : '0));
      if (rst_edge[cyc]) begin
        chk("reset Owner", 64'(Owner), 64'(0));
        chk("reset PacketIn", 64'(PacketIn), 64'(0));
      end
      if (sbq.size() > 0 && sbq[0].done_edge < cyc) begin
        h = sbq.pop_front();
        chk("completion missed", 64'(h.done_edge), 64'(cyc));
      end
      if (sbq.size() > 0 && sbq[0].done_edge == cyc) begin
        h = sbq.pop_front();
        chk("GntDnStr", 64'(GntDnStr), h.granted ? 64'(1) << h.owner : 64'(0));
        chk("TimeoutErr", 64'(TimeoutErr), 64'(!h.granted));
        chk("Owner", 64'(Owner), 64'(h.owner));
        chk("PacketIn", 64'(PacketIn), 64'(h.data));
      end else begin
        chk("GntDnStr idle", 64'(GntDnStr), 64'(0));
        chk("TimeoutErr idle", 64'(TimeoutErr), 64'(0));
      end
    end
  end

  // Driver and reference model: decides, for the upcoming edge e, what the arbiter must do.
  initial begin
    logic [NP-1:0] req;
    logic [31:0]   pdata [NP];
    logic [NP-1:0] en_mask;
    int m_ptr, m_free, pend_done, m_owner;
    bit pend;

    for (int x = 0; x < MAXE; x++) drop_at[x] = -1;
    req = '0; en_mask = '1;
    for (int i = 0; i < NP; i++) pdata[i] = '0;
    reset = 1'b1; ReqDnStr = '0; PacketOut = '0; GntUpStr = 1'b0; UpStrFull = 1'b0;
    rst_edge[1] = 1'b1;
    m_ptr = NP - 1; m_free = 0; pend = 1'b0; pend_done = 0; m_owner = 0;

    for (int n = 0; n < NCYC + 60; n++) begin
      int e;
      bit rst;
      @(negedge clk);
      e = cyc + 1;
      if (n >= NCYC) en_mask = '0;
      else if (n % 500 == 0) en_mask = NP'($urandom_range(1, (1 << NP) - 1));
      rst = (e <= 2) || (n < NCYC && $urandom_range(0, 299) == 0);
      UpStrFull = (n < NCYC) && ($urandom_range(0, 3) == 0);

      if (drop_at[e] >= 0) req[drop_at[e]] = 1'b0;
      for (int i = 0; i < NP; i++) begin
        if (!en_mask[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i]   = 1'b1;
          pdata[i] = $urandom;
        end
      end
      // Owner withdrawing mid-transaction must not disturb the latched flit.
      if (pend && e <= pend_done && !rst && $urandom_range(0, 15) == 0) req[m_owner] = 1'b0;

      if (rst) begin
        rst_edge[e] = 1'b1;
        m_ptr  = NP - 1;
        m_free = e + 1;
        if (pend && e <= pend_done) void'(sbq.pop_back());
        pend = 1'b0;
        for (int x = e; x <= e + 20; x++) begin
          exp_req[x] = 1'b0; exp_busy[x] = 1'b0; exp_full[x] = '0;
          gnt_sched[x] = 1'b0; drop_at[x] = -1;
        end
      end else if (e >= m_free && req != '0 && !UpStrFull) begin
        int w, d, k, r;
        exp_t it;
        w = -1;
        for (int s = 1; s <= NP; s++)
          if (w < 0 && req[(m_ptr + s) % NP]) w = (m_ptr + s) % NP;
        r = $urandom_range(0, 9);
        if (r <= 5)      d = 1;
        else if (r == 6) d = $urandom_range(2, 5);
        else if (r == 7) d = TO;
        else if (r == 8) d = TO + 1;
        else             d = $urandom_range(1, TO);
        k = (d <= TO) ? d : TO;
        it.done_edge = e + k; it.owner = w; it.data = pdata[w]; it.granted = (d <= TO);
        sbq.push_back(it);
        for (int x = e; x < e + k; x++) exp_req[x] = 1'b1;
        for (int x = e; x <= e + k; x++) begin
          exp_busy[x] = 1'b1;
          exp_full[x] = NP'(~(NP'(1) << w));
        end
        if (d <= TO) begin
          gnt_sched[e + d]   = 1'b1;
          drop_at[e + k + 1] = w;
        end
        m_free = e + k + 2; m_ptr = w; m_owner = w; pend = 1'b1; pend_done = e + k;
      end

      reset     = rst;
      GntUpStr  = rst ? 1'b0 : gnt_sched[e];
      ReqDnStr  = req;
      for (int i = 0; i < NP; i++) PacketOut[i*DW +: DW] = pdata[i];
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard drained", 64'(sbq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
